// File: rtl/spi_slave_rx_tx.sv
// SPI responder: oversampled SCLK/MOSI/SS_N, MSB-first word shift in both directions, valid/ack rx register.
// Optional sticky overrun flag built only when SPI_SLAVE_OVERRUN_EN is defined.
module spi_slave_rx_tx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CPOL,
  input  logic                  CPHA,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_load,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  ovr_clr,
  input  logic                  SCLK,
  input  logic                  SS_N,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync, mosi_sync, ss_sync;
  logic                    sclk_d, ss_d;
  logic                    cpol_r, cpha_r;
  logic [CW-1:0]           bit_cnt;
  logic                    first_edge, skip_shift;
  logic [DATA_WIDTH-1:0]   rx_shift, tx_shift;

  logic sclk_s, mosi_s, ss_s;
  logic ss_fall, ss_rise, sclk_edge, leading, trailing;
  logic sample_edge, shift_edge, word_complete;
  logic [DATA_WIDTH-1:0] rx_word;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  assign ss_fall     = ss_d & ~ss_s;
  assign ss_rise     = ~ss_d & ss_s;
  assign sclk_edge   = sclk_s ^ sclk_d;
  assign leading     = sclk_edge & (sclk_d == cpol_r);
  assign trailing    = sclk_edge & (sclk_s == cpol_r);
  assign sample_edge = cpha_r ? trailing : leading;
  assign shift_edge  = cpha_r ? leading : trailing;
  assign rx_word     = {rx_shift[DATA_WIDTH-2:0], mosi_s};
  assign word_complete = (state == ACTIVE) & ~ss_rise & sample_edge & (bit_cnt == LAST);

  assign MISO = MISO_OE & tx_shift[DATA_WIDTH-1];

  // SS_N synchronizer resets low so a select held through reset never looks like a fresh fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_N};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cpol_r     <= 1'b0;
      cpha_r     <= 1'b0;
      bit_cnt    <= '0;
      first_edge <= 1'b0;
      skip_shift <= 1'b0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      tx_load    <= 1'b0;
      busy       <= 1'b0;
      MISO_OE    <= 1'b0;
    end else begin
      tx_load <= 1'b0;
      if (rx_ack) rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          cpol_r <= CPOL;
          cpha_r <= CPHA;
          if (ss_fall) begin
            state      <= ACTIVE;
            bit_cnt    <= '0;
            first_edge <= 1'b1;
            skip_shift <= 1'b0;
            tx_shift   <= tx_data;
            tx_load    <= 1'b1;
            busy       <= 1'b1;
            MISO_OE    <= 1'b1;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state   <= IDLE;
            busy    <= 1'b0;
            MISO_OE <= 1'b0;
          end else if (sample_edge) begin
            rx_shift <= rx_word;
            if (bit_cnt == LAST) begin
              bit_cnt    <= '0;
              rx_data    <= rx_word;
              rx_valid   <= 1'b1;
              tx_shift   <= tx_data;
              tx_load    <= 1'b1;
              // Freshly loaded MSB is already on MISO; the next shift edge must not consume it.
              skip_shift <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (shift_edge) begin
            first_edge <= 1'b0;
            if ((first_edge && cpha_r) || skip_shift)
              skip_shift <= 1'b0;
            else
              tx_shift <= tx_shift << 1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic ovr_q;
  always_ff @(posedge clk) begin
    if (reset)
      ovr_q <= 1'b0;
    else if (word_complete && rx_valid && !rx_ack)
      ovr_q <= 1'b1;
    else if (ovr_clr)
      ovr_q <= 1'b0;
  end
  assign overrun = ovr_q;
`else
  logic unused_ovr;
  assign unused_ovr = ovr_clr ^ word_complete;
  assign overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Bench for spi_slave_rx_tx: bit-banged SPI master, rx-word scoreboard drained by an independent monitor.
module tb_spi_slave_rx_tx;

`ifdef SPI_SLAVE_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif
  localparam int SS = 2;
  localparam int H  = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpol = 1'b0, cpha = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ack = 1'b0;
  logic       busy, overrun, ovr_clr = 1'b0;
  logic       sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe;

  int checks = 0;
  int passes = 0;
  int load_cnt = 0;
  logic [7:0] exp_q[$];

  spi_slave_rx_tx dut (
    .clk(clk), .reset(reset), .CPOL(cpol), .CPHA(cpha), .tx_data(tx_data), .tx_load(tx_load),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack), .busy(busy), .overrun(overrun),
    .ovr_clr(ovr_clr), .SCLK(sclk), .SS_N(ss_n), .MOSI(mosi), .MISO(miso), .MISO_OE(miso_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every newly presented rx word is matched against the scoreboard.
  initial begin
    logic       prev_v;
    logic [7:0] prev_d, e;
    prev_v = 1'b0;
    prev_d = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset && rx_valid && (!prev_v || rx_data != prev_d)) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL rx_unexpected: got 0x%0h expected no word", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_word", rx_data, e);
        end
      end
      prev_v = rx_valid;
      prev_d = rx_data;
    end
  end

  initial forever begin
    @(negedge clk);
    if (tx_load) load_cnt++;
  end

  task automatic start_frame(input logic pol, input logic pha);
    cpol = pol;
    cpha = pha;
    sclk = pol;
    wait_clk(10);
    ss_n = 1'b0;
    wait_clk(H);
  endtask

  // After the final sample edge, optionally pulse rx_ack in exactly the completion cycle.
  task automatic edge_wait(input bit ack_here);
    if (ack_here) begin
      wait_clk(SS);
      rx_ack = 1'b1;
      wait_clk(1);
      rx_ack = 1'b0;
      wait_clk(H - SS - 1);
    end else begin
      wait_clk(H);
    end
  endtask

  task automatic shift_bits(input logic [15:0] w, input int n, input bit ack_last,
                            output logic [15:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      if (!cpha) begin
        mosi = w[n-1-i];
        wait_clk(H);
        got[n-1-i] = miso;
        sclk = ~cpol;
        edge_wait(ack_last && (i == n-1));
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = w[n-1-i];
        wait_clk(H);
        got[n-1-i] = miso;
        sclk = cpol;
        edge_wait(ack_last && (i == n-1));
      end
    end
  endtask

  task automatic end_frame();
    wait_clk(H);
    ss_n = 1'b1;
    wait_clk(SS + 2);
    check("busy_drop", busy, 0);
    check("miso_oe_drop", miso_oe, 0);
    wait_clk(H);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    wait_clk(1);
    rx_ack = 1'b0;
    wait_clk(1);
    check("ack_clears_valid", rx_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_miso_oe"}, miso_oe, 0);
    check({tag, "_miso"}, miso, 0);
    check({tag, "_tx_load"}, tx_load, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    logic [15:0] got;
    int l0;

    wait_clk(5);
    reset = 1'b0;
    wait_clk(2);
    check_reset_outputs("reset");

    // Mode 0: slave sends A5, master sends 3C.
    tx_data = 8'hA5;
    l0 = load_cnt;
    exp_q.push_back(8'h3C);
    start_frame(1'b0, 1'b0);
    check("busy_active", busy, 1);
    shift_bits(16'h003C, 8, 1'b0, got);
    end_frame();
    check("mode0_miso", got, 16'h00A5);
    check("mode0_tx_load_cnt", load_cnt - l0, 2);
    check("mode0_rx_valid", rx_valid, 1);
    ack_pulse();

    // Modes 1..3: master 81, slave 7E.
    for (int m = 1; m < 4; m++) begin
      tx_data = 8'h7E;
      exp_q.push_back(8'h81);
      start_frame(m[1], m[0]);
      shift_bits(16'h0081, 8, 1'b0, got);
      end_frame();
      check($sformatf("mode%0d_miso", m), got, 16'h007E);
      ack_pulse();
    end

    // Back-to-back words without ack; tx word changes between words.
    tx_data = 8'hC3;
    l0 = load_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    start_frame(1'b0, 1'b0);
    tx_data = 8'h3C;
    shift_bits(16'h1122, 16, 1'b0, got);
    end_frame();
    check("b2b_miso", got, 16'hC33C);
    check("b2b_tx_load_cnt", load_cnt - l0, 3);
    check("b2b_overrun", overrun, OVR_EN);
    ovr_clr = 1'b1;
    wait_clk(1);
    ovr_clr = 1'b0;
    wait_clk(1);
    check("ovr_clr", overrun, 0);
    ack_pulse();

    // Frame cut after 5 bits, then a clean frame.
    start_frame(1'b0, 1'b0);
    shift_bits(16'h00F0, 5, 1'b0, got);
    end_frame();
    check("partial_rx_valid", rx_valid, 0);
    check("partial_rx_data", rx_data, 8'h22);
    exp_q.push_back(8'h69);
    start_frame(1'b0, 1'b0);
    shift_bits(16'h0069, 8, 1'b0, got);
    end_frame();
    check("after_partial_valid", rx_valid, 1);
    ack_pulse();

    // Word left pending, then next completion coincides with rx_ack.
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h96);
    start_frame(1'b0, 1'b0);
    shift_bits(16'h0055, 8, 1'b0, got);
    end_frame();
    start_frame(1'b0, 1'b0);
    shift_bits(16'h0096, 8, 1'b1, got);
    end_frame();
    check("ack_same_cycle_valid", rx_valid, 1);
    check("ack_same_cycle_data", rx_data, 8'h96);
    check("ack_same_cycle_overrun", overrun, 0);
    ack_pulse();

    // Reset mid-word with SS_N held low.
    tx_data = 8'hFF;
    start_frame(1'b0, 1'b0);
    shift_bits(16'h0007, 3, 1'b0, got);
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(1);
    check_reset_outputs("midreset");
    wait_clk(20);
    check("no_frame_while_low", busy, 0);
    ss_n = 1'b1;
    wait_clk(10);
    exp_q.push_back(8'hE7);
    start_frame(1'b0, 1'b0);
    check("fresh_frame_busy", busy, 1);
    shift_bits(16'h00E7, 8, 1'b0, got);
    end_frame();
    check("fresh_frame_miso", got, 16'h00FF);
    ack_pulse();

    wait_clk(20);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
